// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master PicoRV32 memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arbiter.sv
// Two-master / one-slave arbiter for the PicoRV32 native memory bus (CPU = m0,
// loader = m1), with a watchdog that force-completes unacknowledged transfers.
//
// state | meaning
// IDLE  | no owner; any request is granted at the next edge
// BUSY  | owner drives the slave until s_ready or watchdog expiry
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int          PRIORITY_MODE  = 0,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic        timeout_err,
    output logic [31:0] timeout_addr
);

    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    // A disabled watchdog still needs a legal 1-bit counter.
    localparam int WD_W = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_EN ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

    arb_state_t      state, state_nxt;
    logic            owner, owner_nxt;
    logic            last_owner, last_owner_nxt;
    logic [WD_W-1:0] wd_cnt;

    logic busy;
    logic sel_m0;
    logic sel_m1;
    logic start;
    logic pick;
    logic expiry;
    logic done;

    assign busy   = (state == BUSY);
    assign sel_m0 = busy && (owner == ARB_M0);
    assign sel_m1 = busy && (owner == ARB_M1);
    assign start  = !busy && (m0_valid || m1_valid);

    // Completion by the slave takes precedence over a same-cycle expiry.
    assign expiry = WD_EN && busy && !s_ready && (wd_cnt == WD_LAST);
    assign done   = busy && (s_ready || expiry);

    always_comb begin
        pick = ARB_M0;
        if (m0_valid && m1_valid) begin
            pick = (PRIORITY_MODE == 1) ? ARB_M1 : ~last_owner;
        end else if (m1_valid) begin
            pick = ARB_M1;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = BUSY;
                    owner_nxt = pick;
                end
            end
            BUSY: begin
                if (done) begin
                    state_nxt      = IDLE;
                    last_owner_nxt = owner;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= ARB_M0;
            last_owner <= ARB_M1;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt       <= '0;
            timeout_err  <= 1'b0;
            timeout_addr <= '0;
        end else begin
            if (start) begin
                wd_cnt <= '0;
            end else if (busy && WD_EN) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            // Only the first timeout's address is kept for post-mortem.
            if (expiry) begin
                timeout_err <= 1'b1;
                if (!timeout_err) begin
                    timeout_addr <= s_addr;
                end
            end
        end
    end

    assign s_valid = busy;
    assign s_instr = sel_m0 ? m0_instr : 1'b0;
    assign s_addr  = sel_m1 ? m1_addr  : (sel_m0 ? m0_addr  : '0);
    assign s_wdata = sel_m1 ? m1_wdata : (sel_m0 ? m0_wdata : '0);
    assign s_wstrb = sel_m1 ? m1_wstrb : (sel_m0 ? m0_wstrb : '0);

    assign m0_ready = done && (owner == ARB_M0);
    assign m1_ready = done && (owner == ARB_M1);
    assign m0_rdata = expiry ? ERR_RDATA : s_rdata;
    assign m1_rdata = expiry ? ERR_RDATA : s_rdata;

    assign grant = {sel_m1, sel_m0};

endmodule
